jstk_conditioner: RTL and testbench
===================================

Name: jstk_conditioner

Overview:
- Input stage directly upstream of GameManager.
- Converts raw joystick direction/button levels into clean, debounced, single-cycle game events with held-direction auto-repeat.
- Drives GameManager's jstkPos/jstkPress inputs so one physical move equals exactly one cursor step, and a sustained hold steps at a controlled rate.
- Contains a 2-FF synchronizer, per-group debounce counters, an edge detector and an auto-repeat FSM.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a level is accepted (>=1)
REPEAT_DELAY, 10, cycles from the first move pulse to the first auto-repeat pulse (>=2)
REPEAT_RATE, 3, cycles between subsequent auto-repeat pulses (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  event enable; debouncing runs regardless
raw_pos  input  4  async direction levels: bit0 up, bit1 down, bit2 left, bit3 right
raw_press  input  1  async button level
jstkPos  output  4  one-cycle move pulse, one-hot, same bit encoding as raw_pos
jstkPress  output  1  one-cycle press pulse
held_dir  output  4  debounced direction level, unqualified
press_level  output  1  debounced button level

Behaviour:
- Reset: rst sampled high clears all state. Synchronizer regs, candidates, counters, held_dir, press_level, jstkPos and jstkPress all go to 0. FSM goes to IDLE. No pulse is issued in the reset cycle or the cycle after. Reset mid-repeat aborts the sequence with no trailing pulse.
- Synchronizer: raw_pos and raw_press each pass through 2 flops (s1 -> s2).
- Debounce: one independent instance for the 4-bit pos group and one for the press bit.
  - If s2 != cand: cand <= s2, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= cand; cnt holds.
  - Else: cnt++.
  - Any change in the pos vector restarts the pos counter.
  - held_dir and press_level are the stable registers.
- Latency: a raw change held steady reaches stable on clock edge D+3 after the change (D = DEBOUNCE_CYCLES). The registered pulse appears on edge D+4 and stays high for exactly 1 cycle. With D=4 the pulse is on edge 8.
- dir_valid = held_dir has exactly one bit set. Zero bits or multiple bits (diagonal, opposing) are invalid and produce no move events.
- Auto-repeat FSM with states IDLE, FIRST, REPEAT and a repeat counter rc:
  - IDLE: if dir_valid && en: jstkPos <= held_dir, latch cur_dir, rc <= 0, go to FIRST.
  - FIRST: if !dir_valid || !en: go to IDLE. Else if held_dir != cur_dir: pulse the new dir, latch it, rc <= 0, stay in FIRST. Else if rc == REPEAT_DELAY-1: pulse cur_dir, rc <= 0, go to REPEAT. Else rc++.
  - REPEAT: same exit and direction-change rules as FIRST (a direction change goes to FIRST). Pulse when rc == REPEAT_RATE-1, then rc <= 0.
- Resulting timing: pulses at cycles t0, t0+REPEAT_DELAY, then every REPEAT_RATE cycles.
- jstkPos is 0 in every cycle without a pulse, and never has more than one bit set.
- Press: jstkPress <= press_level rising edge && en. Press never repeats. Falling edges produce nothing.
- Move and press pulses are independent and may coincide in the same cycle.
- en low: FSM is forced to IDLE and all pulses are suppressed. held_dir and press_level keep tracking.
- en rising while a valid direction is held: treated as a new hold, so a pulse occurs on the next edge.
- Counter widths: $clog2(param)+1. Counters never wrap because they saturate or reset at the terminal count.

Test Plan:
(All scenarios use D=4, REPEAT_DELAY=10, REPEAT_RATE=3. Edge numbers are counted from the raw change.)
1. Glitch: raw_pos=0001 for 3 cycles, then 0000 -> held_dir stays 0000 and jstkPos has no pulse.
2. Hold up: raw_pos=0001 held for 40 cycles -> jstkPos=0001 pulses at edges 8, 18, 21, 24, 27, ... Release -> held_dir drops after the debounce delay and no pulse follows.
3. Press: raw_press=1 held for 20 cycles -> a single jstkPress pulse at edge 8; press_level=1; releasing and re-pressing yields exactly one more pulse.
4. Diagonal: raw_pos=0101 held -> held_dir=0101, jstkPos stays 0. Then raw_pos=0100 -> one pulse of 0100 after the debounce delay.
5. Direction change in REPEAT: raw_pos goes from 0001 to 1000 -> the 1000 pulse comes D+4 edges after the change, and its next repeat follows 10 cycles later.
6. Enable and reset:
   - en=0 with up held for 30 cycles -> no pulses.
   - en rising -> pulse on the next edge, then repeats at +10, +13, ...
   - rst=1 for 1 cycle mid-REPEAT -> all outputs 0 and no pulse until a fresh debounce completes.

Source files
------------

// File: rtl/jstk_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jstk_conditioner: sync + debounce + edge detect + auto-repeat for jstk    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+

module jstk_debounce #(
  parameter int W               = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  s1, s2, cand;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any change of the whole group restarts the stability window.
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module jstk_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_RATE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] raw_pos,
  input  logic       raw_press,
  output logic [3:0] jstkPos,
  output logic       jstkPress,
  output logic [3:0] held_dir,
  output logic       press_level
);
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW     = $clog2(RC_MAX) + 1;
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cur_dir, cur_dir_nxt;
  logic [RW-1:0] rc, rc_nxt;
  logic [3:0]    pos_nxt;
  logic          press_prev, press_nxt;
  logic          dir_valid;
  logic [RW-1:0] rc_last;

  jstk_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pos_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (raw_pos),
    .stable (held_dir)
  );

  jstk_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_press_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (raw_press),
    .stable (press_level)
  );

  // Exactly one bit set: diagonals, opposing pairs and no-direction are ignored.
  assign dir_valid = (held_dir != 4'd0) && ((held_dir & (held_dir - 4'd1)) == 4'd0);
  assign rc_last   = (state == FIRST) ? DELAY_LAST : RATE_LAST;
  assign press_nxt = press_level && !press_prev && en;

  always_comb begin
    state_nxt   = state;
    cur_dir_nxt = cur_dir;
    rc_nxt      = rc;
    pos_nxt     = 4'd0;
    case (state)
      IDLE: begin
        if (dir_valid && en) begin
          pos_nxt     = held_dir;
          cur_dir_nxt = held_dir;
          rc_nxt      = '0;
          state_nxt   = FIRST;
        end
      end
      FIRST, REPEAT: begin
        if (!dir_valid || !en) begin
          state_nxt = IDLE;
        end else if (held_dir != cur_dir) begin
          pos_nxt     = held_dir;
          cur_dir_nxt = held_dir;
          rc_nxt      = '0;
          state_nxt   = FIRST;
        end else if (rc == rc_last) begin
          pos_nxt   = cur_dir;
          rc_nxt    = '0;
          state_nxt = REPEAT;
        end else begin
          rc_nxt = rc + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_dir    <= 4'd0;
      rc         <= '0;
      jstkPos    <= 4'd0;
      jstkPress  <= 1'b0;
      press_prev <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_dir    <= cur_dir_nxt;
      rc         <= rc_nxt;
      jstkPos    <= pos_nxt;
      jstkPress  <= press_nxt;
      press_prev <= press_level;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_jstk_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jstk_conditioner: scoreboard bench for jstk_conditioner               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_jstk_conditioner;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [3:0] raw_pos = 4'd0;
  logic       raw_press = 1'b0;
  logic [3:0] jstkPos;
  logic       jstkPress;
  logic [3:0] held_dir;
  logic       press_level;

  jstk_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .raw_pos     (raw_pos),
    .raw_press   (raw_press),
    .jstkPos     (jstkPos),
    .jstkPress   (jstkPress),
    .held_dir    (held_dir),
    .press_level (press_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } ev_t;

  ev_t pos_q[$];
  ev_t press_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_pos(input int t, input logic [3:0] v);
    ev_t e;
    int  i;
    e.cyc = t;
    e.val = v;
    i = 0;
    while (i < pos_q.size() && pos_q[i].cyc <= t) i++;
    pos_q.insert(i, e);
  endtask

  task automatic push_press(input int t);
    ev_t e;
    e.cyc = t;
    e.val = 4'd1;
    press_q.push_back(e);
  endtask

  // First pulse at t0, first repeat RD later, then every RR, while the
  // direction is still seen as held (last valid edge = tlast).
  task automatic push_hold(input logic [3:0] dir, input int t0, input int tlast);
    int t;
    if (t0 <= tlast) push_pos(t0, dir);
    t = t0 + RD;
    while (t <= tlast) begin
      push_pos(t, dir);
      t += RR;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Pulse monitor: every cycle the outputs must equal the scheduled event or 0.
  logic [3:0] m_exp_pos;
  logic       m_exp_press;
  ev_t        m_ev;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_exp_pos   = 4'd0;
      m_exp_press = 1'b0;
      if (pos_q.size() > 0 && pos_q[0].cyc == cyc) begin
        m_ev      = pos_q.pop_front();
        m_exp_pos = m_ev.val;
      end
      if (press_q.size() > 0 && press_q[0].cyc == cyc) begin
        m_ev        = press_q.pop_front();
        m_exp_press = m_ev.val[0];
      end
      check_eq("jstkPos", {28'd0, jstkPos}, {28'd0, m_exp_pos});
      check_eq("jstkPress", {31'd0, jstkPress}, {31'd0, m_exp_press});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int c;
  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_held_dir", {28'd0, held_dir}, 32'd0);
    check_eq("reset_press_level", {31'd0, press_level}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Glitch shorter than the debounce window
    c = cyc;
    raw_pos = 4'b0001;
    wait_cyc(c + 3);
    raw_pos = 4'b0000;
    wait_cyc(c + 8);
    check_eq("glitch_held_dir", {28'd0, held_dir}, 32'd0);
    wait_cyc(c + 20);
    check_eq("glitch_held_dir_late", {28'd0, held_dir}, 32'd0);

    // Hold up, then release
    c = cyc;
    raw_pos = 4'b0001;
    push_hold(4'b0001, c + 8, c + 47);
    wait_cyc(c + 6);
    check_eq("hold_held_before", {28'd0, held_dir}, 32'd0);
    wait_cyc(c + 7);
    check_eq("hold_held_after", {28'd0, held_dir}, 32'd1);
    wait_cyc(c + 40);
    raw_pos = 4'b0000;
    wait_cyc(c + 46);
    check_eq("release_held_before", {28'd0, held_dir}, 32'd1);
    wait_cyc(c + 47);
    check_eq("release_held_after", {28'd0, held_dir}, 32'd0);
    wait_cyc(c + 60);

    // Press, release, re-press
    c = cyc;
    raw_press = 1'b1;
    push_press(c + 8);
    wait_cyc(c + 10);
    check_eq("press_level_high", {31'd0, press_level}, 32'd1);
    wait_cyc(c + 20);
    raw_press = 1'b0;
    wait_cyc(c + 26);
    check_eq("press_level_still", {31'd0, press_level}, 32'd1);
    wait_cyc(c + 27);
    check_eq("press_level_low", {31'd0, press_level}, 32'd0);
    wait_cyc(c + 30);
    raw_press = 1'b1;
    push_press(c + 38);
    wait_cyc(c + 45);
    check_eq("repress_level", {31'd0, press_level}, 32'd1);
    wait_cyc(c + 50);
    raw_press = 1'b0;
    wait_cyc(c + 65);

    // Diagonal gives nothing; single direction afterwards gives one pulse
    c = cyc;
    raw_pos = 4'b0101;
    wait_cyc(c + 12);
    check_eq("diag_held_dir", {28'd0, held_dir}, 32'h5);
    wait_cyc(c + 15);
    raw_pos = 4'b0100;
    push_hold(4'b0100, c + 23, c + 29);
    wait_cyc(c + 22);
    raw_pos = 4'b0000;
    wait_cyc(c + 24);
    check_eq("diag_to_left_held", {28'd0, held_dir}, 32'h4);
    wait_cyc(c + 40);
    check_eq("diag_release_held", {28'd0, held_dir}, 32'd0);

    // Direction change during repeat
    c = cyc;
    raw_pos = 4'b0001;
    push_hold(4'b0001, c + 8, c + 37);
    wait_cyc(c + 30);
    raw_pos = 4'b1000;
    push_hold(4'b1000, c + 38, c + 67);
    wait_cyc(c + 60);
    raw_pos = 4'b0000;
    wait_cyc(c + 80);

    // Enable gating, enable rise, reset mid-repeat
    c = cyc;
    en = 1'b0;
    raw_pos = 4'b0001;
    wait_cyc(c + 10);
    check_eq("en_low_held_dir", {28'd0, held_dir}, 32'd1);
    wait_cyc(c + 30);
    en = 1'b1;
    push_hold(4'b0001, c + 31, c + 50);
    wait_cyc(c + 50);
    rst = 1'b1;
    wait_cyc(c + 51);
    rst = 1'b0;
    check_eq("midreset_held_dir", {28'd0, held_dir}, 32'd0);
    check_eq("midreset_press_level", {31'd0, press_level}, 32'd0);
    push_hold(4'b0001, c + 59, c + 82);
    wait_cyc(c + 75);
    raw_pos = 4'b0000;
    wait_cyc(c + 95);

    check_eq("pos_events_left", pos_q.size(), 32'd0);
    check_eq("press_events_left", press_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
